// File: rtl/sram_6w_write_sched.sv
// Write-side scheduler for the six-write-port SRAM: identity-initialises the low rows
// after reset, then drains an age-ordered queue onto ports 0..5 (oldest on port 0).
module sram_6w_write_sched #(
   parameter int SRAM_DEPTH   = 16,
   parameter int SRAM_INDEX   = 4,
   parameter int SRAM_WIDTH   = 8,
   parameter int INIT_ENTRIES = 8,
   parameter int QUEUE_DEPTH  = 8,
   parameter int QUEUE_INDEX  = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid_i,
   input  logic                  req1_valid_i,
   input  logic                  req2_valid_i,
   input  logic [SRAM_INDEX-1:0] req0_addr_i,
   input  logic [SRAM_INDEX-1:0] req1_addr_i,
   input  logic [SRAM_INDEX-1:0] req2_addr_i,
   input  logic [SRAM_WIDTH-1:0] req0_data_i,
   input  logic [SRAM_WIDTH-1:0] req1_data_i,
   input  logic [SRAM_WIDTH-1:0] req2_data_i,
   input  logic                  stall_i,
   output logic                  ready_o,
   output logic                  init_done_o,
   output logic [QUEUE_INDEX:0]  count_o,
   output logic                  we0_o,
   output logic                  we1_o,
   output logic                  we2_o,
   output logic                  we3_o,
   output logic                  we4_o,
   output logic                  we5_o,
   output logic [SRAM_INDEX-1:0] addr0wr_o,
   output logic [SRAM_INDEX-1:0] addr1wr_o,
   output logic [SRAM_INDEX-1:0] addr2wr_o,
   output logic [SRAM_INDEX-1:0] addr3wr_o,
   output logic [SRAM_INDEX-1:0] addr4wr_o,
   output logic [SRAM_INDEX-1:0] addr5wr_o,
   output logic [SRAM_WIDTH-1:0] data0wr_o,
   output logic [SRAM_WIDTH-1:0] data1wr_o,
   output logic [SRAM_WIDTH-1:0] data2wr_o,
   output logic [SRAM_WIDTH-1:0] data3wr_o,
   output logic [SRAM_WIDTH-1:0] data4wr_o,
   output logic [SRAM_WIDTH-1:0] data5wr_o
);
   localparam int NPORT = 6;
   localparam int NLANE = 3;
   // Wide enough for idx+k while walking up to SRAM_DEPTH rows in steps of six.
   localparam int IDX_W = $clog2(SRAM_DEPTH + 13);
   localparam logic [QUEUE_INDEX:0] READY_MAX = (QUEUE_INDEX + 1)'(QUEUE_DEPTH - NLANE);
   localparam logic [QUEUE_INDEX:0] DRAIN_MAX = (QUEUE_INDEX + 1)'(NPORT);

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
   localparam state_t RESET_STATE = (INIT_ENTRIES > 0) ? ST_INIT : ST_RUN;

   state_t                 state_r, state_nxt_s;
   logic [IDX_W-1:0]       idx_r, idx_nxt_s, row_s;
   logic                   init_done_r, init_done_nxt_s;
   logic [QUEUE_INDEX-1:0] head_r, head_nxt_s, tail_r, tail_nxt_s;
   logic [QUEUE_INDEX:0]   count_r, count_nxt_s;
   logic [SRAM_INDEX-1:0]  q_addr_r [QUEUE_DEPTH];
   logic [SRAM_WIDTH-1:0]  q_data_r [QUEUE_DEPTH];
   logic [NPORT-1:0]       we_r, we_nxt_s;
   logic [SRAM_INDEX-1:0]  addr_r [NPORT];
   logic [SRAM_INDEX-1:0]  addr_nxt_s [NPORT];
   logic [SRAM_WIDTH-1:0]  data_r [NPORT];
   logic [SRAM_WIDTH-1:0]  data_nxt_s [NPORT];
   logic [NLANE-1:0]       lane_valid_s, enq_en_s;
   logic [SRAM_INDEX-1:0]  lane_addr_s [NLANE];
   logic [SRAM_WIDTH-1:0]  lane_data_s [NLANE];
   logic [QUEUE_INDEX-1:0] enq_ptr_s [NLANE];
   logic [1:0]             n_enq_s;
   logic [2:0]             n_drain_s;
   logic                   ready_s;

   assign lane_valid_s   = {req2_valid_i, req1_valid_i, req0_valid_i};
   assign lane_addr_s[0] = req0_addr_i;
   assign lane_addr_s[1] = req1_addr_i;
   assign lane_addr_s[2] = req2_addr_i;
   assign lane_data_s[0] = req0_data_i;
   assign lane_data_s[1] = req1_data_i;
   assign lane_data_s[2] = req2_data_i;

   assign ready_s = (state_r == ST_RUN) && (count_r <= READY_MAX);

   // Next-state, enqueue slot placement and write-port selection
   always_comb begin
      state_nxt_s     = state_r;
      idx_nxt_s       = idx_r;
      init_done_nxt_s = init_done_r;
      head_nxt_s      = head_r;
      tail_nxt_s      = tail_r;
      count_nxt_s     = count_r;
      we_nxt_s        = '0;
      addr_nxt_s      = addr_r;
      data_nxt_s      = data_r;
      row_s           = '0;
      enq_en_s        = '0;
      n_enq_s         = 2'd0;
      n_drain_s       = 3'd0;
      for (int l = 0; l < NLANE; l++) begin
         enq_ptr_s[l] = tail_r;
      end
      case (state_r)
         ST_INIT: begin
            for (int k = 0; k < NPORT; k++) begin
               row_s         = idx_r + IDX_W'(k);
               we_nxt_s[k]   = (row_s < IDX_W'(INIT_ENTRIES));
               addr_nxt_s[k] = SRAM_INDEX'(row_s);
               data_nxt_s[k] = SRAM_WIDTH'(row_s);
            end
            idx_nxt_s = idx_r + IDX_W'(NPORT);
            if (idx_nxt_s >= IDX_W'(INIT_ENTRIES)) begin
               state_nxt_s     = ST_RUN;
               init_done_nxt_s = 1'b1;
            end else begin
               state_nxt_s     = ST_INIT;
            end
         end
         ST_RUN: begin
            init_done_nxt_s = 1'b1;
            // Valid lanes pack into consecutive tail slots, lane 0 first.
            for (int l = 0; l < NLANE; l++) begin
               enq_ptr_s[l] = tail_r + QUEUE_INDEX'(n_enq_s);
               if (ready_s && lane_valid_s[l]) begin
                  enq_en_s[l] = 1'b1;
                  n_enq_s     = n_enq_s + 2'd1;
               end else begin
                  enq_en_s[l] = 1'b0;
               end
            end
            if (stall_i) begin
               n_drain_s = 3'd0;
            end else if (count_r > DRAIN_MAX) begin
               n_drain_s = 3'(NPORT);
            end else begin
               n_drain_s = 3'(count_r);
            end
            for (int k = 0; k < NPORT; k++) begin
               if (3'(k) < n_drain_s) begin
                  we_nxt_s[k]   = 1'b1;
                  addr_nxt_s[k] = q_addr_r[head_r + QUEUE_INDEX'(k)];
                  data_nxt_s[k] = q_data_r[head_r + QUEUE_INDEX'(k)];
               end else begin
                  we_nxt_s[k]   = 1'b0;
               end
            end
            head_nxt_s  = head_r + QUEUE_INDEX'(n_drain_s);
            tail_nxt_s  = tail_r + QUEUE_INDEX'(n_enq_s);
            count_nxt_s = count_r + (QUEUE_INDEX + 1)'(n_enq_s) - (QUEUE_INDEX + 1)'(n_drain_s);
         end
         default: begin
            state_nxt_s = RESET_STATE;
         end
      endcase
   end

   // Control state, init walk index and queue pointers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= RESET_STATE;
         idx_r       <= '0;
         init_done_r <= 1'b0;
         head_r      <= '0;
         tail_r      <= '0;
         count_r     <= '0;
      end else begin
         state_r     <= state_nxt_s;
         idx_r       <= idx_nxt_s;
         init_done_r <= init_done_nxt_s;
         head_r      <= head_nxt_s;
         tail_r      <= tail_nxt_s;
         count_r     <= count_nxt_s;
      end
   end

   // Queue entry storage
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            q_addr_r[i] <= '0;
            q_data_r[i] <= '0;
         end
      end else begin
         for (int l = 0; l < NLANE; l++) begin
            if (enq_en_s[l]) begin
               q_addr_r[enq_ptr_s[l]] <= lane_addr_s[l];
               q_data_r[enq_ptr_s[l]] <= lane_data_s[l];
            end
         end
      end
   end

   // Registered SRAM write ports
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_r <= '0;
         for (int k = 0; k < NPORT; k++) begin
            addr_r[k] <= '0;
            data_r[k] <= '0;
         end
      end else begin
         we_r   <= we_nxt_s;
         addr_r <= addr_nxt_s;
         data_r <= data_nxt_s;
      end
   end

   assign ready_o     = ready_s;
   assign init_done_o = init_done_r;
   assign count_o     = count_r;
   assign {we5_o, we4_o, we3_o, we2_o, we1_o, we0_o} = we_r;
   assign addr0wr_o = addr_r[0];
   assign addr1wr_o = addr_r[1];
   assign addr2wr_o = addr_r[2];
   assign addr3wr_o = addr_r[3];
   assign addr4wr_o = addr_r[4];
   assign addr5wr_o = addr_r[5];
   assign data0wr_o = data_r[0];
   assign data1wr_o = data_r[1];
   assign data2wr_o = data_r[2];
   assign data3wr_o = data_r[3];
   assign data4wr_o = data_r[4];
   assign data5wr_o = data_r[5];
endmodule

// File: tb/tb_sram_6w_write_sched.sv
// Bench for sram_6w_write_sched: directed scenarios plus random traffic checked against
// a queue-based reference model and an SRAM model written by the DUT's ports.
module tb_sram_6w_write_sched;
   localparam int SD = 16;
   localparam int SI = 4;
   localparam int SW = 8;
   localparam int IE = 8;
   localparam int QD = 8;
   localparam int QI = 3;

   typedef struct {
      logic [SI-1:0] addr;
      logic [SW-1:0] data;
   } ent_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          stall;
   logic [2:0]    lv;
   logic [SI-1:0] la [3];
   logic [SW-1:0] ld [3];

   wire           ready;
   wire           done;
   wire [QI:0]    count;
   wire [5:0]     we_v;
   wire [6*SI-1:0] addr_v;
   wire [6*SW-1:0] data_v;

   int checks = 0;
   int fails  = 0;

   // reference model state
   ent_t           mq[$];
   bit             m_run;
   bit             m_done;
   int             m_row;
   logic [5:0]     e_we;
   logic [6*SI-1:0] e_addr;
   logic [6*SW-1:0] e_data;
   logic [SW-1:0]  ref_mem [SD];
   bit             ref_ok [SD];
   logic [SW-1:0]  dut_mem [SD];

   sram_6w_write_sched #(
      .SRAM_DEPTH(SD), .SRAM_INDEX(SI), .SRAM_WIDTH(SW),
      .INIT_ENTRIES(IE), .QUEUE_DEPTH(QD), .QUEUE_INDEX(QI)
   ) dut (
      .clk(clk), .reset(reset),
      .req0_valid_i(lv[0]), .req1_valid_i(lv[1]), .req2_valid_i(lv[2]),
      .req0_addr_i(la[0]), .req1_addr_i(la[1]), .req2_addr_i(la[2]),
      .req0_data_i(ld[0]), .req1_data_i(ld[1]), .req2_data_i(ld[2]),
      .stall_i(stall), .ready_o(ready), .init_done_o(done), .count_o(count),
      .we0_o(we_v[0]), .we1_o(we_v[1]), .we2_o(we_v[2]),
      .we3_o(we_v[3]), .we4_o(we_v[4]), .we5_o(we_v[5]),
      .addr0wr_o(addr_v[3:0]), .addr1wr_o(addr_v[7:4]), .addr2wr_o(addr_v[11:8]),
      .addr3wr_o(addr_v[15:12]), .addr4wr_o(addr_v[19:16]), .addr5wr_o(addr_v[23:20]),
      .data0wr_o(data_v[7:0]), .data1wr_o(data_v[15:8]), .data2wr_o(data_v[23:16]),
      .data3wr_o(data_v[31:24]), .data4wr_o(data_v[39:32]), .data5wr_o(data_v[47:40])
   );

   always #5 clk = ~clk;

   // SRAM attached to the DUT: ports applied in order so the highest port wins
   always @(posedge clk) begin
      for (int k = 0; k < 6; k++) begin
         if (we_v[k]) dut_mem[addr_v[k*SI +: SI]] <= data_v[k*SW +: SW];
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      mq.delete();
      m_run  = (IE == 0);
      m_done = 1'b0;
      m_row  = 0;
      e_we   = '0;
      e_addr = '0;
      e_data = '0;
   endtask

   // one clock edge: advances the model alongside the DUT, ends #1 after the edge
   task automatic cycle();
      bit   rdy;
      int   n;
      int   r;
      ent_t e;
      rdy = m_run && ((QD - mq.size()) >= 3);
      if ((|lv) && !rdy) $display("note: request presented while not ready, dropped");
      @(posedge clk);
      for (int k = 0; k < 6; k++) begin
         if (e_we[k]) begin
            ref_mem[e_addr[k*SI +: SI]] = e_data[k*SW +: SW];
            ref_ok[e_addr[k*SI +: SI]]  = 1'b1;
         end
      end
      if (!m_run) begin
         for (int k = 0; k < 6; k++) begin
            r = m_row + k;
            e_we[k]            = (r < IE);
            e_addr[k*SI +: SI] = SI'(r);
            e_data[k*SW +: SW] = SW'(r);
         end
         m_row = m_row + 6;
         if (m_row >= IE) begin
            m_run  = 1'b1;
            m_done = 1'b1;
         end
      end else begin
         m_done = 1'b1;
         e_we   = '0;
         if (!stall) begin
            n = (mq.size() > 6) ? 6 : mq.size();
            for (int k = 0; k < n; k++) begin
               e = mq.pop_front();
               e_we[k]            = 1'b1;
               e_addr[k*SI +: SI] = e.addr;
               e_data[k*SW +: SW] = e.data;
            end
         end
         if (rdy) begin
            for (int l = 0; l < 3; l++) begin
               if (lv[l]) begin
                  e.addr = la[l];
                  e.data = ld[l];
                  mq.push_back(e);
               end
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      stall = 1'b0;
      lv    = 3'b000;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (we_v !== 6'd0 || addr_v !== 24'd0 || data_v !== 48'd0) begin
         $display("FAIL reset_ports got we=%b addr=%h data=%h exp all zero", we_v, addr_v, data_v);
         fails++;
      end
      checks++;
      if (count !== 4'd0 || done !== 1'b0 || ready !== 1'b0) begin
         $display("FAIL reset_ctrl got count=%0d done=%b ready=%b exp 0/0/0", count, done, ready);
         fails++;
      end
      reset = 1'b1;
   endtask

   task automatic test_init();
      cycle();
      checks++;
      if (we_v !== 6'b111111 || addr_v !== {4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0} ||
          data_v !== {8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}) begin
         $display("FAIL init_c1 got we=%b addr=%h data=%h exp we=111111 rows 0..5", we_v, addr_v, data_v);
         fails++;
      end
      checks++;
      if (done !== 1'b0 || ready !== 1'b0) begin
         $display("FAIL init_c1_ctrl got done=%b ready=%b exp 0/0", done, ready);
         fails++;
      end
      cycle();
      checks++;
      if (we_v !== 6'b000011 || addr_v[7:0] !== {4'd7, 4'd6} || data_v[15:0] !== {8'd7, 8'd6}) begin
         $display("FAIL init_c2 got we=%b addr=%h data=%h exp we=000011 rows 6,7", we_v, addr_v, data_v);
         fails++;
      end
      checks++;
      if (done !== 1'b1 || ready !== 1'b1 || count !== 4'd0) begin
         $display("FAIL init_c2_ctrl got done=%b ready=%b count=%0d exp 1/1/0", done, ready, count);
         fails++;
      end
   endtask

   task automatic test_latency();
      lv = 3'b001; la[0] = 4'd3; ld[0] = 8'hA5;
      cycle();
      lv = 3'b000;
      checks++;
      if (count !== 4'd1 || we_v !== 6'd0) begin
         $display("FAIL lat_enq got count=%0d we=%b exp 1/000000", count, we_v);
         fails++;
      end
      cycle();
      checks++;
      if (we_v !== 6'b000001 || addr_v[3:0] !== 4'd3 || data_v[7:0] !== 8'hA5 || count !== 4'd0) begin
         $display("FAIL lat_port got we=%b addr0=%h data0=%h count=%0d exp 000001/3/a5/0",
                  we_v, addr_v[3:0], data_v[7:0], count);
         fails++;
      end
      cycle();
      checks++;
      if (dut_mem[3] !== 8'hA5) begin
         $display("FAIL lat_sram got row3=%h exp a5", dut_mem[3]);
         fails++;
      end
   endtask

   task automatic test_same_addr();
      lv = 3'b111;
      la[0] = 4'd5; la[1] = 4'd5; la[2] = 4'd5;
      ld[0] = 8'h11; ld[1] = 8'h22; ld[2] = 8'h33;
      cycle();
      lv = 3'b000;
      cycle();
      checks++;
      if (we_v !== 6'b000111 || addr_v[11:0] !== {4'd5, 4'd5, 4'd5} ||
          data_v[23:0] !== {8'h33, 8'h22, 8'h11}) begin
         $display("FAIL same_addr_ports got we=%b addr=%h data=%h exp 000111 row5 11/22/33",
                  we_v, addr_v, data_v);
         fails++;
      end
      cycle();
      checks++;
      if (dut_mem[5] !== 8'h33) begin
         $display("FAIL same_addr_sram got row5=%h exp 33", dut_mem[5]);
         fails++;
      end
   endtask

   task automatic test_stall_fill();
      stall = 1'b1;
      lv = 3'b111;
      la[0] = 4'd10; la[1] = 4'd11; la[2] = 4'd12;
      ld[0] = 8'h60; ld[1] = 8'h61; ld[2] = 8'h62;
      cycle();
      checks++;
      if (ready !== 1'b1) begin
         $display("FAIL fill_ready3 got ready=%b exp 1", ready);
         fails++;
      end
      la[0] = 4'd13; la[1] = 4'd14; la[2] = 4'd15;
      ld[0] = 8'h63; ld[1] = 8'h64; ld[2] = 8'h65;
      cycle();
      lv = 3'b000;
      checks++;
      if (count !== 4'd6 || ready !== 1'b0 || we_v !== 6'd0) begin
         $display("FAIL fill_full got count=%0d ready=%b we=%b exp 6/0/000000", count, ready, we_v);
         fails++;
      end
      stall = 1'b0;
      cycle();
      checks++;
      if (we_v !== 6'b111111 || addr_v !== {4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10} ||
          data_v !== {8'h65, 8'h64, 8'h63, 8'h62, 8'h61, 8'h60} || count !== 4'd0) begin
         $display("FAIL fill_drain got we=%b addr=%h data=%h count=%0d exp all six in age order, count 0",
                  we_v, addr_v, data_v, count);
         fails++;
      end
   endtask

   task automatic test_compaction();
      lv = 3'b101;
      la[0] = 4'd1; la[1] = 4'd7; la[2] = 4'd9;
      ld[0] = 8'h71; ld[1] = 8'hEE; ld[2] = 8'h79;
      cycle();
      lv = 3'b000;
      cycle();
      checks++;
      if (we_v !== 6'b000011 || addr_v[7:0] !== {4'd9, 4'd1} || data_v[15:0] !== {8'h79, 8'h71}) begin
         $display("FAIL compaction got we=%b addr=%h data=%h exp 000011 rows 1,9",
                  we_v, addr_v[7:0], data_v[15:0]);
         fails++;
      end
   endtask

   task automatic test_reset_mid();
      stall = 1'b1;
      lv = 3'b111;
      la[0] = 4'd2; la[1] = 4'd3; la[2] = 4'd4;
      ld[0] = 8'h82; ld[1] = 8'h83; ld[2] = 8'h84;
      cycle();
      lv = 3'b001; la[0] = 4'd8; ld[0] = 8'h88;
      cycle();
      lv = 3'b000;
      checks++;
      if (count !== 4'd4) begin
         $display("FAIL mid_count got count=%0d exp 4", count);
         fails++;
      end
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      checks++;
      if (we_v !== 6'd0 || addr_v !== 24'd0 || data_v !== 48'd0 || count !== 4'd0 || ready !== 1'b0) begin
         $display("FAIL mid_async got we=%b addr=%h data=%h count=%0d ready=%b exp all zero",
                  we_v, addr_v, data_v, count, ready);
         fails++;
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      stall = 1'b0;
      cycle();
      checks++;
      if (we_v !== 6'b111111 || addr_v !== {4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0} || done !== 1'b0) begin
         $display("FAIL mid_reinit got we=%b addr=%h done=%b exp 111111 rows 0..5 done 0", we_v, addr_v, done);
         fails++;
      end
      cycle();
      checks++;
      if (we_v !== 6'b000011 || done !== 1'b1) begin
         $display("FAIL mid_reinit2 got we=%b done=%b exp 000011/1", we_v, done);
         fails++;
      end
   endtask

   task automatic test_random();
      bit rdy;
      for (int c = 0; c < 400; c++) begin
         stall = ($urandom_range(3, 0) == 0);
         rdy   = m_run && ((QD - mq.size()) >= 3);
         lv    = rdy ? 3'($urandom_range(7, 0)) : 3'b000;
         for (int l = 0; l < 3; l++) begin
            la[l] = SI'($urandom);
            ld[l] = SW'($urandom);
         end
         checks++;
         if (ready !== rdy) begin
            $display("FAIL rand_ready cyc=%0d got %b exp %b", c, ready, rdy);
            fails++;
         end
         cycle();
         checks++;
         if (we_v !== e_we || addr_v !== e_addr || data_v !== e_data) begin
            $display("FAIL rand_ports cyc=%0d got we=%b addr=%h data=%h exp we=%b addr=%h data=%h",
                     c, we_v, addr_v, data_v, e_we, e_addr, e_data);
            fails++;
         end
         checks++;
         if (count !== (QI + 1)'(mq.size()) || done !== m_done) begin
            $display("FAIL rand_ctrl cyc=%0d got count=%0d done=%b exp %0d/%b", c, count, done, mq.size(), m_done);
            fails++;
         end
      end
      stall = 1'b0;
      lv    = 3'b000;
      repeat (4) cycle();
      for (int r = 0; r < SD; r++) begin
         if (ref_ok[r]) begin
            checks++;
            if (dut_mem[r] !== ref_mem[r]) begin
               $display("FAIL rand_sram row=%0d got %h exp %h", r, dut_mem[r], ref_mem[r]);
               fails++;
            end
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      stall = 1'b0;
      lv    = 3'b000;
      for (int l = 0; l < 3; l++) begin
         la[l] = '0;
         ld[l] = '0;
      end
      for (int r = 0; r < SD; r++) begin
         ref_ok[r]  = 1'b0;
         ref_mem[r] = '0;
      end
      test_reset();
      test_init();
      test_latency();
      test_same_addr();
      test_stall_fill();
      test_compaction();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
